traffic_phase_scheduler: RTL



---
 rtl/traffic_phase_scheduler.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/traffic_phase_scheduler.sv
// ============================================================================
// Module      : traffic_phase_scheduler
// Description : Two-road intersection controller. Road A rests in green and
//               road B is served on demand. Includes a pedestrian walk phase
//               and emergency preemption toward road A. Each phase is timed
//               by a saturating duration counter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module traffic_phase_scheduler #(
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 6,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Sa,
    input  logic       Sb,
    input  logic       ped_req,
    input  logic       emerg_a,
    output logic       Ra,
    output logic       Ya,
    output logic       Ga,
    output logic       Rb,
    output logic       Yb,
    output logic       Gb,
    output logic       walk,
    output logic [2:0] phase,
    output logic       ped_pending
);

    // Phase encodings; the value is exported directly on the phase output
    localparam logic [2:0] c_A_GREEN  = 3'd0;
    localparam logic [2:0] c_A_YELLOW = 3'd1;
    localparam logic [2:0] c_ALLRED_AB = 3'd2;
    localparam logic [2:0] c_B_GREEN  = 3'd3;
    localparam logic [2:0] c_B_YELLOW = 3'd4;
    localparam logic [2:0] c_ALLRED_BA = 3'd5;
    localparam logic [2:0] c_PED_WALK = 3'd6;

    // Counter thresholds: an exit fires on the edge where cnt reaches T-1
    localparam logic [CNT_W-1:0] c_GMIN_LAST   = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] c_GMAX_LAST   = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] c_YELLOW_LAST = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] c_ALLRED_LAST = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] c_WALK_LAST   = CNT_W'(WALK_T - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX     = {CNT_W{1'b1}};

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ped_pending;
    logic             r_ret_b;        // walk was entered on the way to road B

    logic [2:0]       w_next_state;
    logic             w_next_ret_b;
    logic             w_state_change;
    logic             w_enter_walk;
    logic             w_gmin_done;

    assign w_gmin_done = (r_cnt >= c_GMIN_LAST);

    // Next-phase selection from current phase, elapsed time and requests
    always_comb begin
        w_next_state = r_state;
        w_next_ret_b = r_ret_b;
        case (r_state)
            c_A_GREEN: begin
                if (w_gmin_done && (Sb || r_ped_pending) && !emerg_a)
                    w_next_state = c_A_YELLOW;
            end
            c_A_YELLOW: begin
                if (r_cnt == c_YELLOW_LAST)
                    w_next_state = c_ALLRED_AB;
            end
            c_ALLRED_AB: begin
                if (r_cnt == c_ALLRED_LAST) begin
                    if (r_ped_pending && !emerg_a) begin
                        w_next_state = c_PED_WALK;
                        w_next_ret_b = 1'b1;
                    end else if (emerg_a) begin
                        w_next_state = c_A_GREEN;
                    end else begin
                        w_next_state = c_B_GREEN;
                    end
                end
            end
            c_B_GREEN: begin
                if (emerg_a || (r_cnt == c_GMAX_LAST) ||
                    (w_gmin_done && (!Sb || Sa || r_ped_pending)))
                    w_next_state = c_B_YELLOW;
            end
            c_B_YELLOW: begin
                if (r_cnt == c_YELLOW_LAST)
                    w_next_state = c_ALLRED_BA;
            end
            c_ALLRED_BA: begin
                if (r_cnt == c_ALLRED_LAST) begin
                    if (r_ped_pending && !emerg_a) begin
                        w_next_state = c_PED_WALK;
                        w_next_ret_b = 1'b0;
                    end else begin
                        w_next_state = c_A_GREEN;
                    end
                end
            end
            c_PED_WALK: begin
                if (r_cnt == c_WALK_LAST) begin
                    if (r_ret_b && Sb && !emerg_a)
                        w_next_state = c_B_GREEN;
                    else
                        w_next_state = c_A_GREEN;
                end
            end
            default: w_next_state = c_A_GREEN;
        endcase
    end

    assign w_state_change = (w_next_state != r_state);
    assign w_enter_walk   = (w_next_state == c_PED_WALK) && (r_state != c_PED_WALK);

    // Phase register and duration counter (cleared on change, saturating)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_A_GREEN;
            r_cnt   <= '0;
            r_ret_b <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ret_b <= w_next_ret_b;
            if (w_state_change)
                r_cnt <= '0;
            else if (r_cnt != c_CNT_MAX)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // Pedestrian request latch; entering the walk phase clears it, and that
    // clear takes priority over a request arriving on the same edge
    always_ff @(posedge clk) begin
        if (reset)
            r_ped_pending <= 1'b0;
        else if (w_enter_walk)
            r_ped_pending <= 1'b0;
        else if (ped_req && (r_state != c_PED_WALK))
            r_ped_pending <= 1'b1;
    end

    // Moore lamp decode; an unreachable encoding shows all-red for safety
    always_comb begin
        Ra   = 1'b0;
        Ya   = 1'b0;
        Ga   = 1'b0;
        Rb   = 1'b0;
        Yb   = 1'b0;
        Gb   = 1'b0;
        walk = 1'b0;
        case (r_state)
            c_A_GREEN:  begin Ga = 1'b1; Rb = 1'b1; end
            c_A_YELLOW: begin Ya = 1'b1; Rb = 1'b1; end
            c_B_GREEN:  begin Gb = 1'b1; Ra = 1'b1; end
            c_B_YELLOW: begin Yb = 1'b1; Ra = 1'b1; end
            c_PED_WALK: begin Ra = 1'b1; Rb = 1'b1; walk = 1'b1; end
            default:    begin Ra = 1'b1; Rb = 1'b1; end
        endcase
    end

    assign phase       = r_state;
    assign ped_pending = r_ped_pending;

endmodule

`default_nettype wire
